// File: rtl/spi_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : spi_pkg
//  Description : Shared types and constants for the parametrised SPI master.
//                FSM state encoding, the {cpol, cpha} mode record and the
//                four standard SPI mode constants.
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        XFER  = 2'd2,
        HOLD  = 2'd3
    } spi_state_t;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    localparam spi_mode_t MODE0 = '{cpol: 1'b0, cpha: 1'b0};
    localparam spi_mode_t MODE1 = '{cpol: 1'b0, cpha: 1'b1};
    localparam spi_mode_t MODE2 = '{cpol: 1'b1, cpha: 1'b0};
    localparam spi_mode_t MODE3 = '{cpol: 1'b1, cpha: 1'b1};

endpackage
`default_nettype wire

// File: rtl/spi_clk_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : spi_clk_gen
//  Description : SCLK divider. While en is high SCLK toggles every CLK_DIV
//                clk cycles; while en is low the divider is cleared and SCLK
//                rests at cpol.
//  Ports       : clk, rst_n (async, active-low), en, cpol
//                SCLK       - serial clock (registered)
//                lead_tick  - strobe in the cycle whose clk edge moves SCLK
//                             away from cpol
//                trail_tick - strobe in the cycle whose clk edge returns SCLK
//                             to cpol
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_clk_gen #(
    parameter int CLK_DIV = 25
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic cpol,
    output logic SCLK,
    output logic lead_tick,
    output logic trail_tick
);

    localparam int                 c_div_w    = $clog2(CLK_DIV);
    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(CLK_DIV - 1);

    logic [c_div_w-1:0] r_div;
    logic               w_wrap;

    // The strobes coincide with the clk edge that toggles SCLK, so the
    // consumer acts on exactly the same edge the slave sees.
    assign w_wrap     = en && (r_div == c_div_last);
    assign lead_tick  = w_wrap && (SCLK == cpol);
    assign trail_tick = w_wrap && (SCLK != cpol);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= '0;
            SCLK  <= 1'b0;
        end else if (!en) begin
            r_div <= '0;
            SCLK  <= cpol;
        end else if (w_wrap) begin
            r_div <= '0;
            SCLK  <= ~SCLK;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_master_param.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : spi_master_param
//  Description : Parametrised full-duplex SPI master, modes 0-3 selectable
//                per transfer, MSB first, start/busy/done handshake, one CS.
//                Build option: SPI_LOOPBACK_EN - samples MOSI instead of MISO.
//  Ports       : clk, rst_n (async, active-low)
//                start, mode[1:0]={CPOL,CPHA}, tx_data - captured in IDLE
//                MISO                                  - slave data in
//                SCLK, MOSI, CS (active-low)           - SPI bus out
//                busy, done (1-cycle), rx_data         - status/result
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_master_param
    import spi_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 25
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              MISO,
    output logic              SCLK,
    output logic              MOSI,
    output logic              CS,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data
);

    localparam int                  c_div_w    = $clog2(CLK_DIV);
    localparam int                  c_edge_w   = $clog2(2*DATA_W + 1);
    localparam logic [c_div_w-1:0]  c_div_last = c_div_w'(CLK_DIV - 1);
    localparam logic [c_edge_w-1:0] c_edge_pen = c_edge_w'(2*DATA_W - 1);
    localparam logic [c_edge_w-1:0] c_edge_all = c_edge_w'(2*DATA_W);

    spi_state_t          r_state;
    spi_mode_t           r_mode;
    spi_mode_t           w_mode_in;
    logic [DATA_W-1:0]   r_tx_sh;
    logic [DATA_W-1:0]   r_rx_sh;
    logic [c_edge_w-1:0] r_edge_cnt;
    logic [c_div_w-1:0]  r_hold_cnt;
    logic                r_en;
    logic                w_lead;
    logic                w_trail;
    logic                w_sample;
    logic                w_cpol;
    logic                w_accept;

    assign w_mode_in = spi_mode_t'(mode);
    assign w_accept  = (r_state == IDLE) && start;

    // Feed the incoming CPOL straight through on the accepting edge so SCLK
    // already sits at the new idle level from the first SETUP cycle.
    assign w_cpol = w_accept ? w_mode_in.cpol : r_mode.cpol;

`ifdef SPI_LOOPBACK_EN
    assign w_sample = MOSI;
`else
    assign w_sample = MISO;
`endif

    spi_clk_gen #(
        .CLK_DIV    (CLK_DIV)
    ) u_clk_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (r_en),
        .cpol       (w_cpol),
        .SCLK       (SCLK),
        .lead_tick  (w_lead),
        .trail_tick (w_trail)
    );

    // The divider runs from the accepting edge, so its first wrap lands H
    // cycles later and is SCLK edge 1 (SETUP -> XFER). It is stopped after
    // edge 2*DATA_W; r_hold_cnt then times the remaining XFER half-period
    // and the HOLD half-period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_mode     <= MODE0;
            r_tx_sh    <= '0;
            r_rx_sh    <= '0;
            r_edge_cnt <= '0;
            r_hold_cnt <= '0;
            r_en       <= 1'b0;
            CS         <= 1'b1;
            MOSI       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            rx_data    <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_mode     <= w_mode_in;
                        r_rx_sh    <= '0;
                        r_edge_cnt <= '0;
                        r_hold_cnt <= '0;
                        r_en       <= 1'b1;
                        CS         <= 1'b0;
                        busy       <= 1'b1;
                        r_state    <= SETUP;
                        // CPHA=0 presents the MSB now; CPHA=1 shifts it out
                        // on the first leading edge, so keep it in the reg.
                        if (w_mode_in.cpha) begin
                            r_tx_sh <= tx_data;
                        end else begin
                            r_tx_sh <= tx_data << 1;
                            MOSI    <= tx_data[DATA_W-1];
                        end
                    end
                end

                SETUP, XFER: begin
                    if (w_lead) begin
                        r_edge_cnt <= r_edge_cnt + 1'b1;
                        r_state    <= XFER;
                        if (r_mode.cpha) begin
                            MOSI    <= r_tx_sh[DATA_W-1];
                            r_tx_sh <= r_tx_sh << 1;
                        end else begin
                            r_rx_sh <= {r_rx_sh[DATA_W-2:0], w_sample};
                        end
                    end else if (w_trail) begin
                        r_edge_cnt <= r_edge_cnt + 1'b1;
                        if (r_mode.cpha) begin
                            r_rx_sh <= {r_rx_sh[DATA_W-2:0], w_sample};
                        end else if (r_edge_cnt != c_edge_pen) begin
                            MOSI    <= r_tx_sh[DATA_W-1];
                            r_tx_sh <= r_tx_sh << 1;
                        end
                        if (r_edge_cnt == c_edge_pen) begin
                            r_en       <= 1'b0;
                            r_hold_cnt <= '0;
                        end
                    end else if (r_edge_cnt == c_edge_all) begin
                        if (r_hold_cnt == c_div_last) begin
                            r_hold_cnt <= '0;
                            r_state    <= HOLD;
                        end else begin
                            r_hold_cnt <= r_hold_cnt + 1'b1;
                        end
                    end
                end

                HOLD: begin
                    if (r_hold_cnt == c_div_last) begin
                        r_hold_cnt <= '0;
                        r_state    <= IDLE;
                        CS         <= 1'b1;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        rx_data    <= r_rx_sh;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_master_param.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_spi_master_param
//  Description : Directed self-checking bench for spi_master_param with
//                DATA_W=8, CLK_DIV=4 and a behavioural SPI slave.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_master_param;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [7:0] tx_data = 8'h00;
    logic       MISO = 1'b0;
    logic       SCLK, MOSI, CS, busy, done;
    logic [7:0] rx_data;

    int n_checks = 0;
    int n_fail   = 0;

    // slave model state
    logic [7:0] slv_data = 8'h00;
    logic [7:0] slv_sh   = 8'h00;
    logic       slv_cpol = 1'b0;
    logic       slv_cpha = 1'b0;
    logic       slv_cs_q = 1'b1;
    logic       slv_sclk_q = 1'b0;

    // per-transfer observations
    int         lat, nrise, nbad, ndone, d1, d2, gap;
    logic [7:0] mbits;
    logic       sclk_p, mosi_p, cs_p;

    spi_master_param #(
        .DATA_W  (8),
        .CLK_DIV (4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .mode    (mode),
        .tx_data (tx_data),
        .MISO    (MISO),
        .SCLK    (SCLK),
        .MOSI    (MOSI),
        .CS      (CS),
        .busy    (busy),
        .done    (done),
        .rx_data (rx_data)
    );

    always #5 clk = ~clk;

    // Slave: loads its word when CS falls, shifts out on the edge opposite
    // to the master's sample edge. Evaluated at negedge when all is settled.
    always @(negedge clk) begin
        if (slv_cs_q && !CS) begin
            slv_sh = slv_data;
            if (!slv_cpha) begin
                MISO   = slv_sh[7];
                slv_sh = slv_sh << 1;
            end
        end else if (!CS && (SCLK != slv_sclk_q)) begin
            if (slv_cpha == (SCLK != slv_cpol)) begin
                MISO   = slv_sh[7];
                slv_sh = slv_sh << 1;
            end
        end
        slv_cs_q   = CS;
        slv_sclk_q = SCLK;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One transfer observed over a fixed 100-cycle window. pulse_at>0 fires
    // an extra start pulse (with tx_data=tx2) at that cycle.
    task automatic run_xfer(input logic [1:0] m, input logic [7:0] tx,
                            input logic [7:0] slv, input int pulse_at,
                            input logic [7:0] tx2);
        @(negedge clk);
        start    = 1'b1;
        mode     = m;
        tx_data  = tx;
        slv_data = slv;
        slv_cpol = m[1];
        slv_cpha = m[0];
        lat = -1; nrise = 0; nbad = 0; ndone = 0; mbits = 8'h00;
        sclk_p = SCLK; mosi_p = MOSI; cs_p = CS;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (i == 1)            start = 1'b0;
            if (i == pulse_at)     begin start = 1'b1; tx_data = tx2; end
            if (i == pulse_at + 1) start = 1'b0;
            if (!CS && !cs_p && !sclk_p && SCLK) begin
                mbits = {mbits[6:0], MOSI};
                nrise++;
            end
            if (!CS && !cs_p && (MOSI != mosi_p) && !(sclk_p && !SCLK)) nbad++;
            if (done) begin
                ndone++;
                if (lat < 0) lat = i - 1;
            end
            sclk_p = SCLK; mosi_p = MOSI; cs_p = CS;
        end
    endtask

    function automatic logic [7:0] exp_rx(input logic [7:0] tx, input logic [7:0] slv);
`ifdef SPI_LOOPBACK_EN
        return tx;
`else
        return slv;
`endif
    endfunction

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        check("rst_cs",   CS,      1);
        check("rst_sclk", SCLK,    0);
        check("rst_mosi", MOSI,    0);
        check("rst_busy", busy,    0);
        check("rst_done", done,    0);
        check("rst_rx",   rx_data, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // mode 0, 0xA5 out, slave 0x3C
        run_xfer(2'b00, 8'hA5, 8'h3C, 0, 8'h00);
        check("m0_latency", lat,     72);
        check("m0_mosi",    mbits,   8'hA5);
        check("m0_rises",   nrise,   8);
        check("m0_mosi_on_fall", nbad, 0);
        check("m0_ndone",   ndone,   1);
        check("m0_rx",      rx_data, exp_rx(8'hA5, 8'h3C));
        check("m0_sclk_idle", SCLK,  0);
        check("m0_cs_idle", CS,      1);

        // mode 3, 0x81 out, slave 0xF0
        run_xfer(2'b11, 8'h81, 8'hF0, 0, 8'h00);
        check("m3_latency", lat,     72);
        check("m3_mosi",    mbits,   8'h81);
        check("m3_mosi_on_fall", nbad, 0);
        check("m3_rx",      rx_data, exp_rx(8'h81, 8'hF0));
        check("m3_sclk_idle", SCLK,  1);

        // start pulsed mid-transfer is ignored
        run_xfer(2'b00, 8'h3C, 8'h99, 20, 8'hFF);
        check("ign_ndone", ndone,   1);
        check("ign_mosi",  mbits,   8'h3C);
        check("ign_rx",    rx_data, exp_rx(8'h3C, 8'h99));
        check("ign_busy",  busy,    0);

        // start held through done: back-to-back with one CS-high cycle
        @(negedge clk);
        start = 1'b1; mode = 2'b00; tx_data = 8'hC3;
        slv_data = 8'h5A; slv_cpol = 1'b0; slv_cpha = 1'b0;
        d1 = -1; d2 = -1; gap = 0; ndone = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                if (d1 < 0) d1 = i;
                else if (d2 < 0) d2 = i;
            end
            if (d1 >= 0 && d2 < 0 && CS) gap++;
            if (d1 >= 0 && !CS) start = 1'b0;
        end
        start = 1'b0;
        check("b2b_first_done", d1, 73);
        check("b2b_spacing",    d2 - d1, 73);
        check("b2b_cs_gap",     gap, 1);
        check("b2b_ndone",      ndone, 2);
        check("b2b_rx",         rx_data, exp_rx(8'hC3, 8'h5A));

        // reset asserted at cycle 30 of a transfer
        @(negedge clk);
        start = 1'b1; mode = 2'b00; tx_data = 8'hFF;
        slv_data = 8'hFF; slv_cpol = 1'b0; slv_cpha = 1'b0;
        for (int i = 1; i < 30; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
        end
        check("rstx_sclk_before", SCLK, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rstx_cs",   CS,   1);
        check("rstx_sclk", SCLK, 0);
        check("rstx_busy", busy, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("rstx_no_done", ndone,   0);
        check("rstx_rx",      rx_data, 0);

        // mode 1, 0x5A out, slave returns 0x00 (loopback build: 0x5A back)
        run_xfer(2'b01, 8'h5A, 8'h00, 0, 8'h00);
        check("m1_latency", lat,     72);
        check("m1_mosi",    mbits,   8'h5A);
        check("m1_rx",      rx_data, exp_rx(8'h5A, 8'h00));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_master_param.md
# spi_master_param

Parametrised SPI master: successor to the fixed mode-0 SCLK generator. It supports runtime-selectable SPI modes 0–3, configurable word width and SCLK divider, full-duplex MOSI/MISO shifting, and a start/busy/done handshake. It sits between a register/control FSM and off-chip SPI slaves, with one chip select per instance.

## Interface
Parameters:
- `DATA_W`, default 8: bits per transfer, MSB first; must be ≥ 2.
- `CLK_DIV`, default 25: SCLK half-period in `clk` cycles (H); must be ≥ 2.
  - SCLK frequency is clk/(2·CLK_DIV).
  - Duty cycle is exactly 50%.

Ports:
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: request a transfer; sampled only in IDLE.
- `mode` in 2: {CPOL, CPHA}; captured with `start`.
- `tx_data` in DATA_W: word to send; captured with `start`.
- `MISO` in 1: serial input from slave.
- `SCLK` out 1: serial clock.
- `MOSI` out 1: serial output.
- `CS` out 1: chip select, active-low.
- `busy` out 1: transfer in progress.
- `done` out 1: one-cycle pulse at transfer end.
- `rx_data` out DATA_W: last received word; held until the next `done`.

## Operation
- FSM states and transitions:
  - IDLE → SETUP when `start`=1.
  - SETUP → XFER after H cycles.
  - XFER → HOLD after 2·DATA_W half-periods.
  - HOLD → IDLE after H cycles.
- Reset values (asynchronous):
  - State IDLE; `CS`=1, `SCLK`=0, `MOSI`=0, `busy`=0, `done`=0, `rx_data`=0.
  - Captured mode=0; shift registers and counters=0.
- IDLE behaviour:
  - `SCLK` = captured CPOL.
  - `CS`=1.
  - `start` latches `mode` and `tx_data`.
- SETUP: `CS`=0, `SCLK` held idle.
  - CPHA=0: MOSI drives tx MSB from the first SETUP cycle.
  - CPHA=1: MOSI drives tx MSB at the first SCLK edge.
- XFER: SCLK toggles every H cycles, giving 2·DATA_W edges. "Leading" means odd edges; "trailing" means even edges.
  - CPHA=0: MISO is sampled on leading edges; MOSI shifts to the next bit on trailing edges, except the last.
  - CPHA=1: MOSI shifts on leading edges; MISO is sampled on trailing edges.
  - Sampling shifts MISO into the LSB of the rx shift register.
- HOLD: `SCLK` idle at CPOL, `CS`=0, MOSI holds the last bit.
- Exit to IDLE:
  - `CS`=1.
  - `rx_data` ← rx shift register.
  - `done`=1 for exactly that cycle.
- `busy`=1 in SETUP, XFER and HOLD; otherwise 0.
- `start` while `busy`=1 is ignored. No queuing; the inputs are not re-captured.
- `start`=1 in the `done` cycle is accepted (state is IDLE), giving back-to-back transfers with a one-cycle CS-high gap.
- Counter widths:
  - Divider: $clog2(CLK_DIV).
  - Edge counter: $clog2(2·DATA_W+1).
  - The divider wraps at CLK_DIV−1 to 0 and produces one tick.
- Reset mid-transfer immediately forces the reset values. The partial word is discarded and `done` is not pulsed.

## Timing
- Let `start` be sampled at rising edge k.
  - `CS` falls and `busy` rises after edge k.
  - First SCLK edge: k+H.
  - Last SCLK edge: k+2·DATA_W·H.
  - `done`, `CS`=1 and valid `rx_data` appear after edge k+(2·DATA_W+2)·H.
  - `busy` falls together with `done`.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- A MISO sample uses the value present at the `clk` edge that generates the corresponding SCLK edge. Slave setup must therefore be met relative to `clk`.

## Configuration
- `SPI_LOOPBACK_EN` defined: the internal sample source is MOSI instead of the `MISO` port.
  - The `MISO` port is ignored.
  - `rx_data` equals the transmitted word after `done`.
- `SPI_LOOPBACK_EN` undefined: the sample source is the `MISO` port, with no loopback logic.

## Structure
- Package `spi_pkg`:
  - `spi_state_t` enum (IDLE, SETUP, XFER, HOLD).
  - `spi_mode_t` packed struct {cpol, cpha}.
  - Mode constants MODE0–MODE3.
- Sub-module `spi_clk_gen`: the divider.
  - Inputs: `clk`, `rst_n`, `en`, `cpol`.
  - Outputs: `SCLK`, plus one-cycle `lead_tick` and `trail_tick` strobes.
- The top level holds the FSM, shift registers and edge counter.

## Test plan
All scenarios use DATA_W=8 and CLK_DIV=4.
- Mode 0, `tx_data`=0xA5, slave returns 0x3C:
  - MOSI shows 1,0,1,0,0,1,0,1 on SCLK rising edges.
  - `rx_data`=0x3C.
  - `done` appears 72 cycles after `start`; SCLK idles low.
- Mode 3, `tx_data`=0x81, slave returns 0xF0:
  - SCLK idles high; MOSI changes on falling edges.
  - `rx_data`=0xF0 with the same 72-cycle latency.
- `start` pulsed at cycle 20 of an active transfer:
  - Ignored: one `done` only; `tx_data` is not re-captured.
- `start` held high through `done`:
  - The second transfer begins; `CS` is high for exactly one cycle between the two.
- `rst_n` low at cycle 30 of a transfer:
  - `CS`=1 and `SCLK`=0 the same cycle; no `done`; `rx_data`=0.
- With `SPI_LOOPBACK_EN`, `tx_data`=0x5A in mode 1:
  - `rx_data`=0x5A; `MISO` tied to 0 has no effect.
